// File: rtl/reg_op_pkg.sv
// Shared definitions for the funsel/e register-operation sequencer.
package reg_op_pkg;

    // Command op codes; identical to the downstream funsel encoding.
    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_DEC   = 2'b10,
        OP_INC   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SETUP = 2'b01,
        PULSE = 2'b10,
        HOLD  = 2'b11
    } state_e;

    // Increment/decrement ops take their pulse count from cmd_count.
    function automatic logic is_step_op(input op_e op);
        return (op == OP_INC) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/reg_op_sequencer.sv
// Sequences funsel/i/e for a downstream register, one command at a time,
// and keeps a shadow copy of the value the register should hold.
module reg_op_sequencer
    import reg_op_pkg::*;
#(
    parameter int unsigned NBits   = 16,
    parameter int unsigned CntBits = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [NBits-1:0]   cmd_data,
    input  logic [CntBits-1:0] cmd_count,
    output logic [1:0]         funsel,
    output logic               e,
    output logic [NBits-1:0]   i,
    output logic               busy,
    output logic               done,
    output logic [NBits-1:0]   shadow
);

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [CntBits-1:0]   steps_q, steps_d;
    logic [NBits-1:0]     i_q, i_d;
    logic [NBits-1:0]     shadow_q, shadow_d;
    logic                 zero_steps;

    // funsel and i are registered at accept, so they settle a full cycle
    // (SETUP) before e rises and stay put until the next accept.
    assign zero_steps = is_step_op(op_q) && (steps_q == '0);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_CLEAR;
            steps_q  <= '0;
            i_q      <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            steps_q  <= steps_d;
            i_q      <= i_d;
            shadow_q <= shadow_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        steps_d  = steps_q;
        i_d      = i_q;
        shadow_d = shadow_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d = op_e'(cmd_op);
                    if (op_e'(cmd_op) == OP_LOAD) begin
                        i_d = cmd_data;
                    end
                    // Clear/load are a single pulse; reuse the step counter.
                    steps_d = is_step_op(op_e'(cmd_op)) ? cmd_count : CntBits'(1);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = zero_steps ? IDLE : PULSE;
            end
            PULSE: begin
                unique case (op_q)
                    OP_CLEAR: shadow_d = '0;
                    OP_LOAD:  shadow_d = i_q;
                    OP_DEC:   shadow_d = shadow_q - NBits'(1);
                    OP_INC:   shadow_d = shadow_q + NBits'(1);
                endcase
                state_d = HOLD;
            end
            HOLD: begin
                steps_d = steps_q - CntBits'(1);
                state_d = (steps_q == CntBits'(1)) ? IDLE : PULSE;
            end
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        cmd_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        e         = (state_q == PULSE);
        done      = ((state_q == SETUP) && zero_steps) ||
                    ((state_q == HOLD) && (steps_q == CntBits'(1)));
        funsel    = op_q;
        i         = i_q;
        shadow    = shadow_q;
    end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Scoreboard bench for reg_op_sequencer with a behavioural downstream register.
module tb_reg_op_sequencer;
    import reg_op_pkg::*;

    localparam int NB = 16;
    localparam int CB = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op = 2'b00;
    logic [NB-1:0] cmd_data = '0;
    logic [CB-1:0] cmd_count = '0;
    logic          cmd_ready, e, busy, done;
    logic [1:0]    funsel;
    logic [NB-1:0] i, shadow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [NB-1:0] shadow;
        int            pulses;
        int            lat;
        string         name;
    } exp_t;
    exp_t sb[$];

    reg_op_sequencer #(.NBits(NB), .CntBits(CB)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
        .funsel(funsel), .e(e), .i(i), .busy(busy), .done(done), .shadow(shadow)
    );

    always #5 clk = ~clk;

    // Downstream register: clear/load act while e=1, inc/dec on e rising.
    logic [NB-1:0] q;
    logic          e_prev;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= '0;
            e_prev <= 1'b0;
        end else begin
            e_prev <= e;
            if (e) begin
                case (funsel)
                    2'b00: q <= '0;
                    2'b01: q <= i;
                    2'b10: if (!e_prev) q <= q - 16'd1;
                    2'b11: if (!e_prev) q <= q + 16'd1;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // funsel/i must never move while e is high.
    always @(funsel or i) begin
        if (rst_n && e) begin
            check("funsel_i_stable_during_e", 32'(e), 32'd0);
        end
    end

    // Monitor: counts busy cycles and pulses, compares on done.
    int cyc = 0;
    int pul = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            cyc = 0;
            pul = 0;
        end else begin
            if (busy) cyc++;
            if (e) pul++;
            if (busy && cmd_ready) check("ready_low_while_busy", 32'(cmd_ready), 32'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    check({x.name, "_shadow"}, 32'(shadow), 32'(x.shadow));
                    check({x.name, "_q"}, 32'(q), 32'(x.shadow));
                    check({x.name, "_pulses"}, pul, x.pulses);
                    check({x.name, "_latency"}, cyc, x.lat);
                end
                cyc = 0;
                pul = 0;
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!cmd_ready && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (busy && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        if (busy) check({name, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    // Called at posedge+1; issues one command and waits for it to finish.
    task automatic issue(input logic [1:0] op, input logic [NB-1:0] data, input logic [CB-1:0] cnt,
                         input logic [NB-1:0] exp_sh, input int exp_p, input int exp_lat,
                         input string name);
        exp_t x;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_count = cnt;
        x.shadow = exp_sh; x.pulses = exp_p; x.lat = exp_lat; x.name = name;
        sb.push_back(x);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_idle(name);
    endtask

    initial begin
        exp_t x;
        int   n;
        int   t;

        // Reset held for three cycles.
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_e", 32'(e), 32'd0);
        check("rst_funsel", 32'(funsel), 32'd0);
        check("rst_shadow", 32'(shadow), 32'd0);
        check("rst_i", 32'(i), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", 32'(cmd_ready), 32'd1);

        // Load then multi-step increment.
        issue(2'b01, 16'hBEEF, 8'd9, 16'hBEEF, 1, 3, "load_beef");
        issue(2'b11, 16'h0000, 8'd3, 16'hBEF2, 3, 7, "inc3");

        // Wrap in both directions, clear.
        issue(2'b01, 16'hFFFF, 8'd0, 16'hFFFF, 1, 3, "load_ffff");
        issue(2'b11, 16'h5555, 8'd2, 16'h0001, 2, 5, "inc2_wrap");
        issue(2'b00, 16'h7777, 8'd4, 16'h0000, 1, 3, "clear");
        issue(2'b10, 16'h0000, 8'd1, 16'hFFFF, 1, 3, "dec1_wrap");

        // Zero-step decrement: done in SETUP, no pulse.
        issue(2'b10, 16'h0000, 8'd0, 16'hFFFF, 0, 1, "dec0");

        // cmd_valid held through a busy command with changing inputs.
        wait_ready();
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 16'hAAAA; cmd_count = 8'd4;
        x.shadow = 16'h0003; x.pulses = 4; x.lat = 9; x.name = "inc4_held";
        sb.push_back(x);
        @(posedge clk); #1;
        t = 0;
        while (busy && t < 100) begin
            cmd_op = 2'b01; cmd_data = 16'($urandom); cmd_count = 8'($urandom);
            @(posedge clk); #1; t++;
        end
        if (busy) check("inc4_held_idle_timeout", 32'(busy), 32'd0);
        cmd_op = 2'b01; cmd_data = 16'h1234; cmd_count = 8'd0;
        x.shadow = 16'h1234; x.pulses = 1; x.lat = 3; x.name = "load_after_held";
        sb.push_back(x);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_idle("load_after_held");

        // Reset during the second pulse of an inc x5.
        wait_ready();
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_count = 8'd5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0; t = 0;
        while (n < 2 && t < 50) begin
            @(negedge clk);
            if (e) n++;
            t++;
        end
        check("abort_saw_second_pulse", 32'(n), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("abort_e", 32'(e), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_shadow", 32'(shadow), 32'd0);
        check("abort_funsel", 32'(funsel), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_ready_after_release", 32'(cmd_ready), 32'd1);

        // Maximum step count, up and back down.
        issue(2'b11, 16'h0000, 8'd255, 16'h00FF, 255, 511, "inc255");
        issue(2'b10, 16'h0000, 8'd255, 16'h0000, 255, 511, "dec255");

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
